load_store_unit: RTL and testbench

//  Sits between the MEM pipeline stage and the word-wide data memory (dmem).

---
 rtl/load_store_unit.sv | 212 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide, event-triggered dmem.
// Latency from accept edge: error 1, load 2, sw 2, sb/sh 3 (read-modify-write).
// Backpressure: req_ready drops on accept and returns the cycle after RESP; responses cannot stall.
// Optional macro LSU_BOUNDS_CHECK_EN: addresses beyond DEPTH words report an error instead of wrapping.
module load_store_unit #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wsrc_q, wsrc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdy_q, rdy_d;
  logic        rvld_q, rvld_d;
  logic        rerr_q, rerr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic        misaligned;
  logic        illegal;
  logic        oob;
  logic        req_bad;
  logic [31:0] word_idx;

  // Pull the addressed lane out of a big-endian word and extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        uns,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'd0:    r = {{24{b[7] & ~uns}}, b};
      2'd1:    r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed big-endian lane of the fetched word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [15:0] wsrc,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    if (size == 2'd0) begin
      case (off)
        2'd0:    r = {wsrc[7:0], word[23:0]};
        2'd1:    r = {word[31:24], wsrc[7:0], word[15:0]};
        2'd2:    r = {word[31:16], wsrc[7:0], word[7:0]};
        default: r = {word[31:8], wsrc[7:0]};
      endcase
    end else if (size == 2'd1) begin
      r = off[1] ? {word[31:16], wsrc} : {wsrc, word[15:0]};
    end
    return r;
  endfunction

  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign illegal    = (req_size == 2'd3);
`ifdef LSU_BOUNDS_CHECK_EN
  assign oob        = |req_addr[31:AW+2];
`else
  // Upper address bits are ignored so the word index wraps modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];
  assign oob            = 1'b0;
`endif
  assign req_bad  = misaligned | illegal | oob;
  assign word_idx = {{(32-AW){1'b0}}, req_addr[AW+1:2]};

  // Next-state, request latching and registered-output decode.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    wsrc_d  = wsrc_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdata_d = 32'd0;
    rerr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_q) begin
          we_d   = req_we;
          size_d = req_size;
          uns_d  = req_uns;
          off_d  = req_addr[1:0];
          wsrc_d = req_wdata[15:0];
          addr_d = word_idx;
          if (req_bad) begin
            state_d = S_RESP;
            rerr_d  = 1'b1;
          end else if (req_we && (req_size == 2'd2)) begin
            state_d = S_WR;
            wdat_d  = req_wdata;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        // mem_rdata is valid by the end of the read strobe cycle.
        if (we_q) begin
          state_d = S_WR;
          wdat_d  = merge_lane(mem_rdata, wsrc_q, size_q, off_q);
        end else begin
          state_d = S_RESP;
          rdata_d = extract_lane(mem_rdata, size_q, uns_q, off_q);
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes follow the next state so each access is a fresh one-cycle pulse.
    rd_d   = (state_d == S_RD);
    wr_d   = (state_d == S_WR);
    rvld_d = (state_d == S_RESP);
    rdy_d  = (state_d == S_IDLE);
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= 2'd0;
      wsrc_q  <= 16'd0;
      addr_q  <= 32'd0;
      wdat_q  <= 32'd0;
      rdata_q <= 32'd0;
      rdy_q   <= 1'b1;
      rvld_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      wsrc_q  <= wsrc_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      rvld_q  <= rvld_d;
      rerr_q  <= rerr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign req_ready  = rdy_q;
  assign resp_valid = rvld_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdat_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner sequences,
// then random traffic checked against a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(512), .AW(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_uns    (req_uns),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  // Event-triggered dmem: acts on the rising edge of each strobe.
  logic [31:0] dmem [0:511];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'd0;

  always @(posedge mem_read) begin
    rd_cnt    = rd_cnt + 1;
    mem_rdata = dmem[mem_addr[8:0]];
  end

  always @(posedge mem_write) begin
    wr_cnt     = wr_cnt + 1;
    last_wdata = mem_wdata;
    dmem[mem_addr[8:0]] = mem_wdata;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain word array plus arithmetic lane rules.
  logic [31:0] ref_mem [0:511];

  function automatic int m_idx(input logic [31:0] addr);
    return int'((addr / 4) % 512);
  endfunction

  function automatic bit m_err(input logic [1:0] size, input logic [31:0] addr);
    bit e;
    e = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    e = e || (addr >= 32'd2048);
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] size,
                                         input bit uns, input logic [31:0] addr);
    logic [31:0] v;
    int k;
    k = int'(addr % 4);
    if (size == 2'd0) begin
      v = (word >> (8 * (3 - k))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (word >> (16 * (1 - k / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] word, input logic [1:0] size,
                                          input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int k, sh, bits;
    if (size == 2'd2) return wdata;
    k    = int'(addr % 4);
    bits = (size == 2'd0) ? 8 : 16;
    sh   = (size == 2'd0) ? 8 * (3 - k) : 16 * (1 - k / 2);
    mask = ((32'd1 << bits) - 32'd1) << sh;
    return (word & ~mask) | ((wdata << sh) & mask);
  endfunction

  // Issue one request and observe it until resp_valid (bounded).
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata, output int lat,
                        output int nrd, output int nwr, output logic [31:0] maddr,
                        output bit addr_moved, output bit strobe_bad, output logic [31:0] wdat);
    int rd0, wr0, guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard = guard + 1;
    end
    if (guard >= 20) chk("req_ready_timeout", req_ready, 32'd1);
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    lat        = 1;
    maddr      = mem_addr;
    addr_moved = 1'b0;
    strobe_bad = mem_read && mem_write;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat = lat + 1;
      if (mem_addr !== maddr) addr_moved = 1'b1;
      if (mem_read && mem_write) strobe_bad = 1'b1;
    end
    if (mem_read || mem_write) strobe_bad = 1'b1;
    err   = resp_err;
    rdata = resp_rdata;
    nrd   = rd_cnt - rd0;
    nwr   = wr_cnt - wr0;
    wdat  = last_wdata;
  endtask

  // Random / model-checked operation.
  task automatic model_op(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    logic e_err, err;
    logic [31:0] e_rd, rdata, maddr, wdat, e_wd;
    int e_lat, lat, nrd, nwr, idx;
    bit moved, sbad;
    idx   = m_idx(addr);
    e_err = m_err(size, addr);
    e_rd  = (!e_err && !we) ? m_load(ref_mem[idx], size, uns, addr) : 32'd0;
    e_lat = e_err ? 1 : ((we && size != 2'd2) ? 3 : 2);
    e_wd  = m_store(ref_mem[idx], size, addr, wdata);
    do_req(we, size, uns, addr, wdata, err, rdata, lat, nrd, nwr, maddr, moved, sbad, wdat);
    chk("rnd_err", err, e_err);
    chk("rnd_rdata", rdata, e_rd);
    chk("rnd_latency", lat, e_lat);
    chk("rnd_reads", nrd, (!e_err && (!we || size != 2'd2)) ? 1 : 0);
    chk("rnd_writes", nwr, (!e_err && we) ? 1 : 0);
    chk("rnd_strobes", {moved, sbad}, 32'd0);
    if (!e_err && we) begin
      chk("rnd_wdata", wdat, e_wd);
      ref_mem[idx] = e_wd;
    end
  endtask

  typedef struct {
    bit          we;
    bit [1:0]    size;
    bit          uns;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    bit          e_err;
    bit [31:0]   e_rdata;
    int          e_lat;
    int          e_nrd;
    int          e_nwr;
    bit [31:0]   e_maddr;
    bit [31:0]   e_wdat;
  } vec_t;

  function automatic vec_t mkv(bit we, bit [1:0] sz, bit uns, bit [31:0] a, bit [31:0] wd,
                               bit ee, bit [31:0] er, int el, int enr, int enw,
                               bit [31:0] ema, bit [31:0] ewd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.e_err = ee; v.e_rdata = er; v.e_lat = el; v.e_nrd = enr; v.e_nwr = enw;
    v.e_maddr = ema; v.e_wdat = ewd;
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    logic err;
    logic [31:0] rdata, maddr, wdat;
    int lat, nrd, nwr, w0;
    bit moved, sbad;

    tbl[0]  = mkv(1, 2, 0, 32'h10,  32'hAABBCCDD, 0, 32'h0,        2, 0, 1, 32'h4,  32'hAABBCCDD);
    tbl[1]  = mkv(0, 2, 0, 32'h10,  32'h0,        0, 32'hAABBCCDD, 2, 1, 0, 32'h4,  32'h0);
    tbl[2]  = mkv(1, 2, 0, 32'h20,  32'h11223344, 0, 32'h0,        2, 0, 1, 32'h8,  32'h11223344);
    tbl[3]  = mkv(1, 0, 0, 32'h21,  32'h000000EE, 0, 32'h0,        3, 1, 1, 32'h8,  32'h11EE3344);
    tbl[4]  = mkv(0, 2, 0, 32'h20,  32'h0,        0, 32'h11EE3344, 2, 1, 0, 32'h8,  32'h0);
    tbl[5]  = mkv(1, 2, 0, 32'h30,  32'h80FF7F01, 0, 32'h0,        2, 0, 1, 32'hC,  32'h80FF7F01);
    tbl[6]  = mkv(0, 0, 0, 32'h31,  32'h0,        0, 32'hFFFFFFFF, 2, 1, 0, 32'hC,  32'h0);
    tbl[7]  = mkv(0, 0, 1, 32'h31,  32'h0,        0, 32'h000000FF, 2, 1, 0, 32'hC,  32'h0);
    tbl[8]  = mkv(0, 1, 0, 32'h30,  32'h0,        0, 32'hFFFF80FF, 2, 1, 0, 32'hC,  32'h0);
    tbl[9]  = mkv(0, 1, 1, 32'h32,  32'h0,        0, 32'h00007F01, 2, 1, 0, 32'hC,  32'h0);
    tbl[10] = mkv(1, 2, 0, 32'h40,  32'h55667788, 0, 32'h0,        2, 0, 1, 32'h10, 32'h55667788);
    tbl[11] = mkv(0, 1, 0, 32'h41,  32'h0,        1, 32'h0,        1, 0, 0, 32'h10, 32'h0);
    tbl[12] = mkv(1, 2, 0, 32'h42,  32'hDEADBEEF, 1, 32'h0,        1, 0, 0, 32'h10, 32'h0);
    tbl[13] = mkv(0, 3, 0, 32'h40,  32'h0,        1, 32'h0,        1, 0, 0, 32'h10, 32'h0);
    tbl[14] = mkv(0, 2, 0, 32'h40,  32'h0,        0, 32'h55667788, 2, 1, 0, 32'h10, 32'h0);
    tbl[15] = mkv(1, 1, 0, 32'h42,  32'hFFFFBEEF, 0, 32'h0,        3, 1, 1, 32'h10, 32'h5566BEEF);
    tbl[16] = mkv(0, 1, 0, 32'h42,  32'h0,        0, 32'hFFFFBEEF, 2, 1, 0, 32'h10, 32'h0);
    tbl[17] = mkv(0, 0, 1, 32'h43,  32'h0,        0, 32'h000000EF, 2, 1, 0, 32'h10, 32'h0);
    tbl[18] = mkv(0, 0, 0, 32'h40,  32'h0,        0, 32'h00000055, 2, 1, 0, 32'h10, 32'h0);
    tbl[19] = mkv(1, 2, 0, 32'h0,   32'hCAFEF00D, 0, 32'h0,        2, 0, 1, 32'h0,  32'hCAFEF00D);
`ifdef LSU_BOUNDS_CHECK_EN
    tbl[20] = mkv(0, 2, 0, 32'h800, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,  32'h0);
`else
    tbl[20] = mkv(0, 2, 0, 32'h800, 32'h0,        0, 32'hCAFEF00D, 2, 1, 0, 32'h0,  32'h0);
`endif

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_uns = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 32'd1);
    chk("reset_resp", {resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 21; i++) begin
      do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
             err, rdata, lat, nrd, nwr, maddr, moved, sbad, wdat);
      chk($sformatf("vec%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].e_lat);
      chk($sformatf("vec%0d_reads", i), nrd, tbl[i].e_nrd);
      chk($sformatf("vec%0d_writes", i), nwr, tbl[i].e_nwr);
      chk($sformatf("vec%0d_mem_addr", i), maddr, tbl[i].e_maddr);
      chk($sformatf("vec%0d_addr_held_no_overlap", i), {moved, sbad}, 32'd0);
      if (tbl[i].e_nwr != 0) chk($sformatf("vec%0d_wdata", i), wdat, tbl[i].e_wdat);
      if (!m_err(tbl[i].size, tbl[i].addr) && tbl[i].we)
        ref_mem[m_idx(tbl[i].addr)] = m_store(ref_mem[m_idx(tbl[i].addr)], tbl[i].size,
                                              tbl[i].addr, tbl[i].wdata);
    end

    // Reset during the RD cycle of a halfword store: no write reaches memory.
    model_op(1, 2'd2, 0, 32'h50, 32'h01020304);
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_we = 1'b1; req_size = 2'd1; req_uns = 1'b0; req_addr = 32'h50; req_wdata = 32'h0000AAAA;
    w0 = wr_cnt;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_rd_read_strobe", mem_read, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_rd_strobes_dropped", {mem_read, mem_write, resp_valid, resp_err}, 32'd0);
    chk("rst_rd_outputs", {resp_rdata | mem_addr}, 32'd0);
    chk("rst_rd_req_ready", req_ready, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_no_write", wr_cnt - w0, 32'd0);
    model_op(0, 2'd2, 0, 32'h50, 32'h0);

    // Reset during the WR cycle of a word store: that write edge still lands.
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h60; req_wdata = 32'h13572468;
    w0 = wr_cnt;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_wr_write_strobe", mem_write, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_wr_strobes_dropped", {mem_read, mem_write, resp_valid}, 32'd0);
    chk("rst_wr_req_ready", req_ready, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wr_one_write", wr_cnt - w0, 32'd1);
    ref_mem[m_idx(32'h60)] = 32'h13572468;
    model_op(0, 2'd2, 0, 32'h60, 32'h0);

    // Random traffic over 32 words, occasionally with upper address bits set.
    for (int i = 0; i < 32; i++) model_op(1, 2'd2, 0, i * 4, $urandom);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 31) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFF800);
      model_op($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
